// File: rtl/fb_write_sequencer_if.sv
// Frame-buffer write bus shared by draw sources and the write sequencer.
// master = draw source side, slave = sequencer (responder) side.
interface fb_write_sequencer_if #(
  parameter int SOURCE_SEL_ADDRW = 2,
  parameter int COLOR_DEPTH      = 9
);
  logic [SOURCE_SEL_ADDRW-1:0] write_source_sel;
  logic                        write_awaited;
  logic                        write_active;
  logic [31:0]                 write_x_addr;
  logic [31:0]                 write_y_addr;
  logic [COLOR_DEPTH-1:0]      write_color_data;
  logic                        write_transparent;

  modport master (
    input  write_source_sel,
    input  write_awaited,
    output write_active,
    output write_x_addr,
    output write_y_addr,
    output write_color_data,
    output write_transparent
  );

  modport slave (
    output write_source_sel,
    output write_awaited,
    input  write_active,
    input  write_x_addr,
    input  write_y_addr,
    input  write_color_data,
    input  write_transparent
  );
endinterface

// File: rtl/fb_write_sequencer.sv
// Grants sources 0..MAX_WRITE_SOURCE per frame, clips pixels, writes RAM.
// Define FB_WSEQ_TIMEOUT_EN to skip sources silent for IDLE_TIMEOUT cycles.
module fb_write_sequencer #(
  parameter int MAX_WRITE_SOURCE = 2,
  parameter int SOURCE_SEL_ADDRW = 2,
  parameter int COLOR_DEPTH      = 9,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int ADDR_W           = 19,
  parameter int IDLE_TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame,
  fb_write_sequencer_if.slave    wr,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [COLOR_DEPTH-1:0] ram_data,
  output logic                   swap_req,
  output logic                   frame_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM,
    S_NEXT,
    S_DONE
  } state_t;

  typedef logic [ADDR_W:0] lin_t;

  localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_SRC =
    SOURCE_SEL_ADDRW'(MAX_WRITE_SOURCE);

  if (((1 << SOURCE_SEL_ADDRW) <= MAX_WRITE_SOURCE)
      || ((64'd1 << ADDR_W)
          < 64'(SCREEN_WIDTH * SCREEN_HEIGHT))
      || (IDLE_TIMEOUT < 1)) begin : g_bad_params
    $error("fb_write_sequencer: inconsistent parameters");
  end

  state_t state;
  logic   frame_pend;
  logic   accept;
  logic   in_bounds;
  logic   do_write;
  lin_t   lin_addr;

`ifdef FB_WSEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            idle_hit;
  assign idle_hit = (idle_cnt == TO_W'(IDLE_TIMEOUT));
`endif

  assign accept = wr.write_awaited && wr.write_active;

  // Full 32-bit compare so huge coordinates never wrap on screen.
  assign in_bounds =
    (wr.write_x_addr < 32'(SCREEN_WIDTH)) &&
    (wr.write_y_addr < 32'(SCREEN_HEIGHT));

  assign lin_addr =
    lin_t'(wr.write_y_addr) * lin_t'(SCREEN_WIDTH) +
    lin_t'(wr.write_x_addr);

  assign do_write =
    accept && in_bounds &&
    !wr.write_transparent && !lin_addr[ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= do_write;
      if (do_write) begin
        ram_addr <= lin_addr[ADDR_W-1:0];
        ram_data <= wr.write_color_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      wr.write_source_sel <= '0;
      wr.write_awaited    <= 1'b0;
      swap_req            <= 1'b0;
      frame_overrun       <= 1'b0;
      frame_pend          <= 1'b0;
`ifdef FB_WSEQ_TIMEOUT_EN
      idle_cnt            <= '0;
`endif
    end else begin
      swap_req      <= 1'b0;
      frame_overrun <= 1'b0;
      frame_pend    <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (frame || frame_pend) begin
            state               <= S_WAIT;
            wr.write_source_sel <= '0;
            wr.write_awaited    <= 1'b1;
`ifdef FB_WSEQ_TIMEOUT_EN
            idle_cnt            <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (frame) begin
            state               <= S_WAIT;
            wr.write_source_sel <= '0;
            wr.write_awaited    <= 1'b1;
            frame_overrun       <= 1'b1;
`ifdef FB_WSEQ_TIMEOUT_EN
            idle_cnt            <= '0;
`endif
          end else if (wr.write_active) begin
            state <= S_STREAM;
`ifdef FB_WSEQ_TIMEOUT_EN
          end else if (idle_hit) begin
            state            <= S_NEXT;
            wr.write_awaited <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
`endif
          end
        end
        S_STREAM: begin
          if (frame) begin
            state               <= S_WAIT;
            wr.write_source_sel <= '0;
            wr.write_awaited    <= 1'b1;
            frame_overrun       <= 1'b1;
`ifdef FB_WSEQ_TIMEOUT_EN
            idle_cnt            <= '0;
`endif
          end else if (!wr.write_active) begin
            state            <= S_NEXT;
            wr.write_awaited <= 1'b0;
          end
        end
        S_NEXT: begin
          // A frame landing on the final NEXT is deferred, not an overrun.
          if (wr.write_source_sel == LAST_SRC) begin
            state      <= S_DONE;
            swap_req   <= 1'b1;
            frame_pend <= frame;
          end else if (frame) begin
            state               <= S_WAIT;
            wr.write_source_sel <= '0;
            wr.write_awaited    <= 1'b1;
            frame_overrun       <= 1'b1;
`ifdef FB_WSEQ_TIMEOUT_EN
            idle_cnt            <= '0;
`endif
          end else begin
            state               <= S_WAIT;
            wr.write_source_sel <= wr.write_source_sel + 1'b1;
            wr.write_awaited    <= 1'b1;
`ifdef FB_WSEQ_TIMEOUT_EN
            idle_cnt            <= '0;
`endif
          end
        end
        default: begin
          state            <= S_IDLE;
          wr.write_awaited <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Bench for fb_write_sequencer: directed frames plus random pixel streams.
// Expected RAM writes come from a clip/linearise model and a queue.
`timescale 1ns/1ps
module tb_fb_write_sequencer;
  localparam int SW = 640;
  localparam int SH = 480;
`ifdef FB_WSEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [8:0]  c;
    logic        t;
  } px_t;

  typedef struct {
    logic [18:0] a;
    logic [8:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        ram_we;
  logic [18:0] ram_addr;
  logic [8:0]  ram_data;
  logic        swap_req;
  logic        frame_overrun;

  fb_write_sequencer_if #(
    .SOURCE_SEL_ADDRW(2),
    .COLOR_DEPTH(9)
  ) wr ();

  fb_write_sequencer #(
    .MAX_WRITE_SOURCE(2),
    .SOURCE_SEL_ADDRW(2),
    .COLOR_DEPTH(9),
    .SCREEN_WIDTH(SW),
    .SCREEN_HEIGHT(SH),
    .ADDR_W(19),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame(frame),
    .wr(wr),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .swap_req(swap_req),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  n_we = 0;
  int  n_push = 0;
  int  n_swap = 0;
  int  n_ovr = 0;
  int  swaps_exp = 0;
  int  ovr_exp = 0;
  wr_t exp_q[$];
  px_t px_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest expected write.
  always begin
    wr_t w;
    @(posedge clk);
    #1;
    if (ram_we === 1'b1) begin
      n_we++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_we: observed addr %0d expected none",
               ram_addr);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("ram_addr", 64'(ram_addr), 64'(w.a));
        chk("ram_data", 64'(ram_data), 64'(w.d));
      end
    end
    if (swap_req === 1'b1) n_swap++;
    if (frame_overrun === 1'b1) n_ovr++;
  end

  function automatic px_t mk(input logic [31:0] x,
                             input logic [31:0] y,
                             input logic [8:0] c,
                             input logic t);
    px_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    p.t = t;
    return p;
  endfunction

  function automatic px_t rand_px();
    px_t p;
    int unsigned k;
    p.x = 32'($urandom_range(0, SW - 1));
    p.y = 32'($urandom_range(0, SH - 1));
    k = $urandom_range(0, 9);
    if (k == 0) p.x = 32'($urandom_range(SW, SW + 500));
    else if (k == 1) p.y = 32'($urandom_range(SH, SH + 500));
    else if (k == 2) p.x = $urandom | 32'h8000_0000;
    p.c = 9'($urandom);
    p.t = ($urandom_range(0, 7) == 0);
    return p;
  endfunction

  task automatic idle();
    wr.write_active      = 1'b0;
    wr.write_x_addr      = '0;
    wr.write_y_addr      = '0;
    wr.write_color_data  = '0;
    wr.write_transparent = 1'b0;
  endtask

  // Valid on-screen pixel driven where it must be ignored.
  task automatic junk();
    wr.write_active      = 1'b1;
    wr.write_x_addr      = 32'd7;
    wr.write_y_addr      = 32'd7;
    wr.write_color_data  = 9'h055;
    wr.write_transparent = 1'b0;
  endtask

  task automatic send(input px_t p);
    wr.write_active      = 1'b1;
    wr.write_x_addr      = p.x;
    wr.write_y_addr      = p.y;
    wr.write_color_data  = p.c;
    wr.write_transparent = p.t;
    if (!p.t && p.x < 32'(SW) && p.y < 32'(SH)) begin
      exp_q.push_back('{
        a: 19'(longint'(p.y) * SW + longint'(p.x)),
        d: p.c});
      n_push++;
    end
  endtask

  task automatic burst(input int s, input int n);
    px_t p;
    for (int i = 0; i < n; i++) begin
      if (px_q.size() > 0) p = px_q.pop_front();
      else p = rand_px();
      send(p);
      @(negedge clk);
      chk("stream_await", 64'(wr.write_awaited), 64'(1));
      chk("stream_sel", 64'(wr.write_source_sel), 64'(s));
    end
  endtask

  // Entered at a negedge; pulse=0 means already at source 0 grant.
  task automatic run_frame(input int n0, input int n1,
                           input int n2, input bit pulse,
                           input bit end_frame);
    int n[3];
    n[0] = n0;
    n[1] = n1;
    n[2] = n2;
    if (pulse) begin
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
    end
    for (int s = 0; s < 3; s++) begin
      chk("grant_sel", 64'(wr.write_source_sel), 64'(s));
      chk("grant_await", 64'(wr.write_awaited), 64'(1));
      if (n[s] == 0) begin
`ifdef FB_WSEQ_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
          @(negedge clk);
          chk("silent_await", 64'(wr.write_awaited), 64'(1));
        end
`else
        repeat (2000) @(negedge clk);
        chk("silent_sel", 64'(wr.write_source_sel), 64'(s));
        chk("silent_await", 64'(wr.write_awaited), 64'(1));
        burst(s, 1);
`endif
      end else begin
        burst(s, n[s]);
      end
      idle();
      @(negedge clk);
      chk("next_await", 64'(wr.write_awaited), 64'(0));
      chk("next_swap", 64'(swap_req), 64'(0));
      junk();
      if (s == 2 && end_frame) frame = 1'b1;
      @(negedge clk);
      if (s < 2) idle();
    end
    chk("done_swap", 64'(swap_req), 64'(1));
    chk("done_await", 64'(wr.write_awaited), 64'(0));
    chk("done_sel", 64'(wr.write_source_sel), 64'(2));
    chk("done_ovr", 64'(frame_overrun), 64'(0));
    chk("done_q_empty", 64'(exp_q.size()), 64'(0));
    frame = 1'b0;
    if (!end_frame) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("hold_await", 64'(wr.write_awaited), 64'(0));
        chk("hold_swap", 64'(swap_req), 64'(0));
      end
    end
    idle();
  endtask

  initial begin
    rst   = 1'b1;
    frame = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_sel", 64'(wr.write_source_sel), 64'(0));
    chk("rst_await", 64'(wr.write_awaited), 64'(0));
    chk("rst_we", 64'(ram_we), 64'(0));
    chk("rst_addr", 64'(ram_addr), 64'(0));
    chk("rst_data", 64'(ram_data), 64'(0));
    chk("rst_swap", 64'(swap_req), 64'(0));
    chk("rst_ovr", 64'(frame_overrun), 64'(0));
    rst = 1'b0;
    junk();
    repeat (3) @(negedge clk);
    chk("idle_await", 64'(wr.write_awaited), 64'(0));
    idle();

    // Basic frame: 3 + 1 + 1 pixels.
    px_q.push_back(mk(32'd0, 32'd0, 9'h1FF, 1'b0));
    px_q.push_back(mk(32'd1, 32'd0, 9'h1FF, 1'b0));
    px_q.push_back(mk(32'd2, 32'd0, 9'h1FF, 1'b0));
    px_q.push_back(mk(32'd639, 32'd479, 9'h0AA, 1'b0));
    px_q.push_back(mk(32'd5, 32'd1, 9'h123, 1'b0));
    run_frame(3, 1, 1, 1'b1, 1'b0);
    swaps_exp++;

    // Clipping and transparency.
    px_q.push_back(mk(32'd640, 32'd0, 9'h011, 1'b0));
    px_q.push_back(mk(32'd0, 32'd480, 9'h022, 1'b0));
    px_q.push_back(mk(32'd3, 32'd3, 9'h033, 1'b1));
    px_q.push_back(mk(32'hFFFF_FFFF, 32'd0, 9'h044, 1'b0));
    px_q.push_back(mk(32'd0, 32'd820, 9'h066, 1'b0));
    px_q.push_back(mk(32'd10, 32'd10, 9'h077, 1'b0));
    px_q.push_back(mk(32'd639, 32'd0, 9'h088, 1'b0));
    run_frame(6, 1, 2, 1'b1, 1'b0);
    swaps_exp++;

    // Frame while source 1 is streaming.
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    burst(0, 2);
    idle();
    repeat (2) @(negedge clk);
    chk("ovr_grant1_sel", 64'(wr.write_source_sel), 64'(1));
    burst(1, 2);
    idle();
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    ovr_exp++;
    chk("ovr_pulse", 64'(frame_overrun), 64'(1));
    chk("ovr_swap", 64'(swap_req), 64'(0));
    chk("ovr_swap_cnt", 64'(n_swap), 64'(swaps_exp));
    run_frame(2, 1, 1, 1'b0, 1'b0);
    swaps_exp++;

    // Frame coinciding with the move to DONE.
    run_frame(2, 2, 2, 1'b1, 1'b1);
    swaps_exp++;
    @(negedge clk);
    run_frame(1, 2, 1, 1'b0, 1'b0);
    swaps_exp++;

    // Silent source 1.
    run_frame(2, 0, 1, 1'b1, 1'b0);
    swaps_exp++;

    for (int f = 0; f < 4; f++) begin
      run_frame(int'($urandom_range(1, 6)),
                int'($urandom_range(1, 6)),
                int'($urandom_range(1, 6)), 1'b1, 1'b0);
      swaps_exp++;
    end

    // Reset in the middle of a stream.
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    burst(0, 3);
    junk();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_sel", 64'(wr.write_source_sel), 64'(0));
    chk("mrst_await", 64'(wr.write_awaited), 64'(0));
    chk("mrst_we", 64'(ram_we), 64'(0));
    chk("mrst_addr", 64'(ram_addr), 64'(0));
    chk("mrst_data", 64'(ram_data), 64'(0));
    chk("mrst_swap", 64'(swap_req), 64'(0));
    chk("mrst_ovr", 64'(frame_overrun), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_idle_await", 64'(wr.write_awaited), 64'(0));
    end
    idle();
    run_frame(1, 1, 1, 1'b1, 1'b0);
    swaps_exp++;

    repeat (3) @(negedge clk);
    chk("final_q_empty", 64'(exp_q.size()), 64'(0));
    chk("final_we_count", 64'(n_we), 64'(n_push));
    chk("final_swaps", 64'(n_swap), 64'(swaps_exp));
    chk("final_overruns", 64'(n_ovr), 64'(ovr_exp));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
